// File: rtl/conv_compute_sequencer_pkg.sv
// rtl/conv_compute_sequencer_pkg.sv - shared state encoding and word geometry for the compute sequencer
package conv_compute_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_DRAIN = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_SHIFT     = 2;

endpackage

// File: rtl/conv_compute_sequencer_if.sv
// rtl/conv_compute_sequencer_if.sv - BRAM read and PE strobe bundle driven by the compute sequencer
interface conv_compute_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              ifm_rd_en;
    logic [ADDR_W-1:0] ifm_rd_addr;
    logic              wgt_rd_en;
    logic [ADDR_W-1:0] wgt_rd_addr;
    logic              pe_acc_valid;
    logic              pe_clear;
    logic              ofm_wr_en;
    logic [ADDR_W-1:0] ofm_wr_addr;

    modport master (
        output ifm_rd_en, ifm_rd_addr, wgt_rd_en, wgt_rd_addr,
        output pe_acc_valid, pe_clear, ofm_wr_en, ofm_wr_addr
    );

    modport slave (
        input ifm_rd_en, ifm_rd_addr, wgt_rd_en, wgt_rd_addr,
        input pe_acc_valid, pe_clear, ofm_wr_en, ofm_wr_addr
    );
endinterface

// File: rtl/conv_loop_counter.sv
// rtl/conv_loop_counter.sv - six-level convolution loop nest with incremental IFM/weight/OFM addressing
module conv_loop_counter
    import conv_compute_sequencer_pkg::*;
#(
    parameter int TOTAL_PE = 16,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [3:0]        kernel_w,
    input  logic [7:0]        ofm_w,
    input  logic [7:0]        ifm_w,
    input  logic [7:0]        ifm_c,
    input  logic [1:0]        stride,
    input  logic [7:0]        tile,
    output logic [ADDR_W-1:0] ifm_byte,
    output logic [ADDR_W-1:0] wgt_byte,
    output logic [ADDR_W-1:0] ofm_addr,
    output logic              first,
    output logic              last,
    output logic              run_end
);
    localparam logic [ADDR_W-1:0] W_STEP = ADDR_W'(BYTES_PER_WORD);
    localparam logic [7:0]        C_STEP = 8'(BYTES_PER_WORD);

    logic [3:0]        k_r, ky, kx;
    logic [7:0]        ofm_r, ifm_c_r, tile_r, t, oy, ox, c;
    logic [ADDR_W-1:0] step_x, step_y, row_bytes, grp_bytes;
    logic [ADDR_W-1:0] row_base, pix_base, win_row, wgt_base;
    logic [ADDR_W-1:0] nxt_win, nxt_pix, nxt_row, nxt_grp;
    logic [1:0]        s_eff;
    logic              c_wrap, kx_wrap, ky_wrap, ox_wrap, oy_wrap, t_wrap;

    assign s_eff   = (stride == 2'd0) ? 2'd1 : stride;
    assign c_wrap  = ({1'b0, c} + 9'd4) >= {1'b0, ifm_c_r};
    assign kx_wrap = kx == k_r - 4'd1;
    assign ky_wrap = ky == k_r - 4'd1;
    assign ox_wrap = ox == ofm_r - 8'd1;
    assign oy_wrap = oy == ofm_r - 8'd1;
    assign t_wrap  = t == tile_r - 8'd1;
    assign first   = (c == 8'd0) && (kx == 4'd0) && (ky == 4'd0);
    assign last    = c_wrap && kx_wrap && ky_wrap;
    assign run_end = last && ox_wrap && oy_wrap && t_wrap;

    assign nxt_win = win_row + row_bytes;
    assign nxt_pix = pix_base + step_x;
    assign nxt_row = row_base + step_y;
    assign nxt_grp = wgt_base + grp_bytes;

    // Step sizes are formed once at load; the run itself only adds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_r <= '0; ofm_r <= '0; ifm_c_r <= '0; tile_r <= '0;
            step_x <= '0; step_y <= '0; row_bytes <= '0; grp_bytes <= '0;
            t <= '0; oy <= '0; ox <= '0; ky <= '0; kx <= '0; c <= '0;
            row_base <= '0; pix_base <= '0; win_row <= '0; wgt_base <= '0;
            ifm_byte <= '0; wgt_byte <= '0; ofm_addr <= '0;
        end else if (load) begin
            k_r       <= kernel_w;
            ofm_r     <= ofm_w;
            ifm_c_r   <= ifm_c;
            tile_r    <= tile;
            step_x    <= ADDR_W'(s_eff) * ADDR_W'(ifm_c);
            row_bytes <= ADDR_W'(ifm_w) * ADDR_W'(ifm_c);
            step_y    <= ADDR_W'(s_eff) * ADDR_W'(ifm_w) * ADDR_W'(ifm_c);
            grp_bytes <= ADDR_W'(TOTAL_PE) * ADDR_W'(kernel_w) * ADDR_W'(kernel_w) * ADDR_W'(ifm_c);
            t <= '0; oy <= '0; ox <= '0; ky <= '0; kx <= '0; c <= '0;
            row_base <= '0; pix_base <= '0; win_row <= '0; wgt_base <= '0;
            ifm_byte <= '0; wgt_byte <= '0; ofm_addr <= '0;
        end else if (step) begin
            // Within one kernel row both addresses are contiguous words.
            if (!c_wrap) begin
                c        <= c + C_STEP;
                ifm_byte <= ifm_byte + W_STEP;
                wgt_byte <= wgt_byte + W_STEP;
            end else begin
                c <= '0;
                if (!kx_wrap) begin
                    kx       <= kx + 4'd1;
                    ifm_byte <= ifm_byte + W_STEP;
                    wgt_byte <= wgt_byte + W_STEP;
                end else begin
                    kx <= '0;
                    if (!ky_wrap) begin
                        ky       <= ky + 4'd1;
                        win_row  <= nxt_win;
                        ifm_byte <= nxt_win;
                        wgt_byte <= wgt_byte + W_STEP;
                    end else begin
                        ky       <= '0;
                        ofm_addr <= ofm_addr + ADDR_W'(1);
                        wgt_byte <= wgt_base;
                        if (!ox_wrap) begin
                            ox       <= ox + 8'd1;
                            pix_base <= nxt_pix;
                            win_row  <= nxt_pix;
                            ifm_byte <= nxt_pix;
                        end else begin
                            ox <= '0;
                            if (!oy_wrap) begin
                                oy       <= oy + 8'd1;
                                row_base <= nxt_row;
                                pix_base <= nxt_row;
                                win_row  <= nxt_row;
                                ifm_byte <= nxt_row;
                            end else begin
                                oy <= '0; row_base <= '0; pix_base <= '0;
                                win_row <= '0; ifm_byte <= '0;
                                if (!t_wrap) begin
                                    t        <= t + 8'd1;
                                    wgt_base <= nxt_grp;
                                    wgt_byte <= nxt_grp;
                                end else begin
                                    t <= '0; wgt_base <= '0; wgt_byte <= '0; ofm_addr <= '0;
                                end
                            end
                        end
                    end
                end
            end
        end
    end
endmodule

// File: rtl/conv_compute_sequencer.sv
// rtl/conv_compute_sequencer.sv - convolution read sequencer: FSM, loop nest and BRAM-latency strobe pipe
module conv_compute_sequencer
    import conv_compute_sequencer_pkg::*;
#(
    parameter int TOTAL_PE = 16,
    parameter int RD_LAT   = 2,
    parameter int ADDR_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cal_start,
    input  logic [3:0]                 KERNEL_W,
    input  logic [7:0]                 OFM_W,
    input  logic [7:0]                 IFM_W,
    input  logic [7:0]                 IFM_C,
    input  logic [1:0]                 stride,
    input  logic [7:0]                 tile,
    conv_compute_sequencer_if.master   bus,
    output logic                       busy,
    output logic                       done_compute
);
    seq_state_t        state, state_next;
    logic [2:0]        drain_cnt;
    logic              rd_en, bad_dims;
    logic [ADDR_W-1:0] ifm_byte, wgt_byte, ofm_addr;
    logic              first, last, run_end;

    logic [RD_LAT-1:0] v_pipe, f_pipe, l_pipe;
    logic [ADDR_W-1:0] a_pipe [RD_LAT];
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;

    assign bad_dims = (OFM_W == 8'd0) || (KERNEL_W == 4'd0) || (IFM_C < 8'd4) || (tile == 8'd0);
    assign rd_en    = (state == SEQ_ISSUE);

    conv_loop_counter #(.TOTAL_PE(TOTAL_PE), .ADDR_W(ADDR_W)) u_loop (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == SEQ_IDLE),
        .step     (rd_en),
        .kernel_w (KERNEL_W),
        .ofm_w    (OFM_W),
        .ifm_w    (IFM_W),
        .ifm_c    (IFM_C),
        .stride   (stride),
        .tile     (tile),
        .ifm_byte (ifm_byte),
        .wgt_byte (wgt_byte),
        .ofm_addr (ofm_addr),
        .first    (first),
        .last     (last),
        .run_end  (run_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEQ_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= (state == SEQ_DRAIN) ? drain_cnt + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SEQ_IDLE:  if (cal_start) state_next = bad_dims ? SEQ_DONE : SEQ_ISSUE;
            SEQ_ISSUE: if (!cal_start) state_next = SEQ_IDLE;
                       else if (run_end) state_next = SEQ_DRAIN;
            SEQ_DRAIN: if (!cal_start) state_next = SEQ_IDLE;
                       else if (drain_cnt == 3'(RD_LAT)) state_next = SEQ_DONE;
            SEQ_DONE:  if (!cal_start) state_next = SEQ_IDLE;
            default:   state_next = SEQ_IDLE;
        endcase
    end

    // Dropping cal_start empties the pipe so nothing reaches the PEs after an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_pipe <= '0; f_pipe <= '0; l_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) a_pipe[i] <= '0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
        end else if (!cal_start) begin
            v_pipe <= '0; f_pipe <= '0; l_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) a_pipe[i] <= '0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
        end else begin
            v_pipe[0] <= rd_en;
            f_pipe[0] <= rd_en & first;
            l_pipe[0] <= rd_en & last;
            a_pipe[0] <= ofm_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                f_pipe[i] <= f_pipe[i-1];
                l_pipe[i] <= l_pipe[i-1];
                a_pipe[i] <= a_pipe[i-1];
            end
            wr_en_r   <= l_pipe[RD_LAT-1];
            wr_addr_r <= a_pipe[RD_LAT-1];
        end
    end

    assign bus.ifm_rd_en    = rd_en;
    assign bus.wgt_rd_en    = rd_en;
    assign bus.ifm_rd_addr  = ifm_byte >> WORD_SHIFT;
    assign bus.wgt_rd_addr  = wgt_byte >> WORD_SHIFT;
    assign bus.pe_acc_valid = v_pipe[RD_LAT-1];
    assign bus.pe_clear     = f_pipe[RD_LAT-1];
    assign bus.ofm_wr_en    = wr_en_r;
    assign bus.ofm_wr_addr  = wr_addr_r;
    assign busy             = (state == SEQ_ISSUE) || (state == SEQ_DRAIN);
    assign done_compute     = (state == SEQ_DONE);
endmodule

// File: tb/tb_conv_compute_sequencer.sv
// tb/tb_conv_compute_sequencer.sv - scoreboard bench for conv_compute_sequencer
module tb_conv_compute_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cal_start = 1'b0;
    logic [3:0] kernel_w = '0;
    logic [7:0] ofm_w = '0, ifm_w = '0, ifm_c = '0, tile = '0;
    logic [1:0] stride = '0;
    logic       busy, done_compute;

    conv_compute_sequencer_if #(.ADDR_W(32)) bus ();

    conv_compute_sequencer #(.TOTAL_PE(16), .RD_LAT(2), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cal_start    (cal_start),
        .KERNEL_W     (kernel_w),
        .OFM_W        (ofm_w),
        .IFM_W        (ifm_w),
        .IFM_C        (ifm_c),
        .stride       (stride),
        .tile         (tile),
        .bus          (bus),
        .busy         (busy),
        .done_compute (done_compute)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] ifm_q[$], wgt_q[$], ofm_q[$];
    bit          clear_q[$];
    bit          mon_en = 1'b0;
    int          n_rd, n_wr, first_rd_cyc, first_wr_cyc;

    always @(posedge clk) cyc++;

    // Scoreboard: pops one expected entry per observed strobe.
    always @(negedge clk) begin
        logic [31:0] e_i, e_w, e_o;
        bit e_c;
        if (mon_en && bus.ifm_rd_en) begin
            n_rd++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            checks++;
            if (ifm_q.size() == 0) begin
                errors++;
                $display("FAIL extra_beat ifm=%0d wgt=%0d required no beat", bus.ifm_rd_addr, bus.wgt_rd_addr);
            end else begin
                e_i = ifm_q.pop_front();
                e_w = wgt_q.pop_front();
                if (bus.ifm_rd_addr !== e_i || bus.wgt_rd_addr !== e_w || bus.wgt_rd_en !== 1'b1) begin
                    errors++;
                    $display("FAIL beat_addr ifm=%0d wgt=%0d wgt_en=%b required ifm=%0d wgt=%0d wgt_en=1",
                             bus.ifm_rd_addr, bus.wgt_rd_addr, bus.wgt_rd_en, e_i, e_w);
                end
            end
        end
        if (mon_en && bus.pe_acc_valid) begin
            checks++;
            if (clear_q.size() == 0) begin
                errors++;
                $display("FAIL extra_acc_valid got 1 required 0");
            end else begin
                e_c = clear_q.pop_front();
                if (bus.pe_clear !== e_c) begin
                    errors++;
                    $display("FAIL pe_clear got %b required %b", bus.pe_clear, e_c);
                end
            end
        end
        if (mon_en && bus.ofm_wr_en) begin
            n_wr++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            checks++;
            if (ofm_q.size() == 0) begin
                errors++;
                $display("FAIL extra_ofm_wr addr=%0d required no write", bus.ofm_wr_addr);
            end else begin
                e_o = ofm_q.pop_front();
                if (bus.ofm_wr_addr !== e_o) begin
                    errors++;
                    $display("FAIL ofm_wr_addr got %0d required %0d", bus.ofm_wr_addr, e_o);
                end
            end
        end
    end

    task automatic build_model(input int k, input int o, input int iw, input int c, input int s, input int tl);
        int se;
        se = (s == 0) ? 1 : s;
        ifm_q.delete(); wgt_q.delete(); ofm_q.delete(); clear_q.delete();
        for (int t = 0; t < tl; t++)
            for (int oy = 0; oy < o; oy++)
                for (int ox = 0; ox < o; ox++) begin
                    for (int ky = 0; ky < k; ky++)
                        for (int kx = 0; kx < k; kx++)
                            for (int cc = 0; cc < c; cc += 4) begin
                                ifm_q.push_back(32'((((oy*se + ky)*iw + ox*se + kx)*c + cc) >> 2));
                                wgt_q.push_back(32'((t*16*k*k*c + (ky*k + kx)*c + cc) >> 2));
                                clear_q.push_back(ky == 0 && kx == 0 && cc == 0);
                            end
                    ofm_q.push_back(32'(t*o*o + oy*o + ox));
                end
    endtask

    task automatic set_dims(input int k, input int o, input int iw, input int c, input int s, input int tl);
        kernel_w = 4'(k); ofm_w = 8'(o); ifm_w = 8'(iw); ifm_c = 8'(c); stride = 2'(s); tile = 8'(tl);
    endtask

    task automatic run_cfg(input string name, input int k, input int o, input int iw, input int c,
                           input int s, input int tl, input bit scramble);
        int exp_rd, exp_wr;
        set_dims(k, o, iw, c, s, tl);
        build_model(k, o, iw, c, s, tl);
        exp_rd = ifm_q.size();
        exp_wr = ofm_q.size();
        n_rd = 0; n_wr = 0; first_rd_cyc = -1; first_wr_cyc = -1;
        @(negedge clk);
        mon_en = 1'b1;
        cal_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (scramble) set_dims(2, 7, 9, 12, 3, 0);
        for (int i = 0; i < 5000 && !done_compute; i++) @(negedge clk);
        checks++;
        if (done_compute !== 1'b1) begin errors++; $display("FAIL %s done_timeout got %b required 1", name, done_compute); end
        checks++;
        if (n_rd != exp_rd) begin errors++; $display("FAIL %s beat_count got %0d required %0d", name, n_rd, exp_rd); end
        checks++;
        if (n_wr != exp_wr) begin errors++; $display("FAIL %s wr_count got %0d required %0d", name, n_wr, exp_wr); end
        checks++;
        if (clear_q.size() != 0) begin errors++; $display("FAIL %s acc_valid_left got %0d required 0", name, clear_q.size()); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_in_done got %b required 0", name, busy); end
        cal_start = 1'b0;
        @(negedge clk);
        checks++;
        if (done_compute !== 1'b0) begin errors++; $display("FAIL %s done_drop got %b required 0", name, done_compute); end
        mon_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cal_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.ifm_rd_en, bus.wgt_rd_en, bus.pe_acc_valid, bus.pe_clear, bus.ofm_wr_en, busy, done_compute} !== 7'b0 ||
            bus.ifm_rd_addr !== 32'd0 || bus.wgt_rd_addr !== 32'd0 || bus.ofm_wr_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs rd=%b addr=%0d/%0d done=%b required all 0", bus.ifm_rd_en,
                     bus.ifm_rd_addr, bus.wgt_rd_addr, done_compute);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_cfg("basic", 1, 2, 2, 4, 1, 1, 1'b0);
        checks++;
        if (first_wr_cyc - first_rd_cyc != 3) begin
            errors++;
            $display("FAIL basic_wr_latency got %0d required 3", first_wr_cyc - first_rd_cyc);
        end
    endtask

    task automatic test_tiles();
        run_cfg("k3_tile2", 3, 2, 4, 8, 1, 2, 1'b1);
    endtask

    task automatic test_stride();
        run_cfg("stride2", 3, 2, 5, 4, 2, 1, 1'b0);
        run_cfg("stride0", 3, 2, 4, 4, 0, 1, 1'b0);
    endtask

    task automatic test_bad_dims(input string name, input int o, input int tl);
        set_dims(1, o, 2, 4, 1, tl);
        ifm_q.delete(); wgt_q.delete(); ofm_q.delete(); clear_q.delete();
        n_rd = 0; n_wr = 0; first_rd_cyc = -1; first_wr_cyc = -1;
        @(negedge clk);
        mon_en = 1'b1;
        cal_start = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (done_compute !== 1'b1) begin errors++; $display("FAIL %s done_fast got %b required 1", name, done_compute); end
        repeat (4) @(negedge clk);
        checks++;
        if (n_rd != 0 || n_wr != 0) begin errors++; $display("FAIL %s no_traffic rd=%0d wr=%0d required 0 0", name, n_rd, n_wr); end
        cal_start = 1'b0;
        @(negedge clk);
        checks++;
        if (done_compute !== 1'b0) begin errors++; $display("FAIL %s done_drop got %b required 0", name, done_compute); end
        mon_en = 1'b0;
    endtask

    task automatic test_abort();
        bit seen;
        set_dims(3, 2, 4, 8, 1, 2);
        build_model(3, 2, 4, 8, 1, 2);
        n_rd = 0; n_wr = 0; first_rd_cyc = -1; first_wr_cyc = -1;
        @(negedge clk);
        mon_en = 1'b1;
        cal_start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (n_rd >= 20) break;
        end
        checks++;
        if (n_rd != 20) begin errors++; $display("FAIL abort_reach_beat20 got %0d required 20", n_rd); end
        cal_start = 1'b0;
        mon_en = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ifm_rd_en !== 1'b0 || bus.wgt_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_rd_low got %b required 0", bus.ifm_rd_en);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.pe_acc_valid || bus.ofm_wr_en || done_compute || bus.ifm_rd_en || busy) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin errors++; $display("FAIL abort_quiet got activity required none"); end
        run_cfg("after_abort", 3, 2, 4, 8, 1, 2, 1'b0);
    endtask

    task automatic test_reset_mid_drain();
        int exp_rd;
        set_dims(1, 2, 2, 4, 1, 1);
        build_model(1, 2, 2, 4, 1, 1);
        @(negedge clk);
        cal_start = 1'b1;
        for (int i = 0; i < 50 && !(busy && !bus.ifm_rd_en); i++) @(negedge clk);
        checks++;
        if (!(busy === 1'b1 && bus.ifm_rd_en === 1'b0)) begin
            errors++;
            $display("FAIL rst_reach_drain busy=%b rd=%b required 1 0", busy, bus.ifm_rd_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ifm_rd_en, bus.pe_acc_valid, bus.pe_clear, bus.ofm_wr_en, busy, done_compute} !== 6'b0 ||
            bus.ofm_wr_addr !== 32'd0 || bus.ifm_rd_addr !== 32'd0 || bus.wgt_rd_addr !== 32'd0) begin
            errors++;
            $display("FAIL rst_async busy=%b wr=%b valid=%b required all 0", busy, bus.ofm_wr_en, bus.pe_acc_valid);
        end
        set_dims(3, 2, 4, 8, 1, 2);
        build_model(3, 2, 4, 8, 1, 2);
        exp_rd = ifm_q.size();
        n_rd = 0; n_wr = 0; first_rd_cyc = -1; first_wr_cyc = -1;
        @(negedge clk);
        mon_en = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 5000 && !done_compute; i++) @(negedge clk);
        checks++;
        if (done_compute !== 1'b1) begin errors++; $display("FAIL rst_rerun_done got %b required 1", done_compute); end
        checks++;
        if (n_rd != exp_rd || n_wr != 8 || ofm_q.size() != 0) begin
            errors++;
            $display("FAIL rst_rerun_counts rd=%0d wr=%0d required %0d 8", n_rd, n_wr, exp_rd);
        end
        cal_start = 1'b0;
        @(negedge clk);
        checks++;
        if (done_compute !== 1'b0) begin errors++; $display("FAIL rst_done_drop got %b required 0", done_compute); end
        mon_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tiles();
        test_stride();
        test_bad_dims("tile0", 2, 0);
        test_bad_dims("ofm0", 0, 1);
        test_abort();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
